crc_feeder: RTL and testbench

- Upstream stage for the CRC accelerator. Buffers data words pushed by the TinyQV bus side in a small FIFO.
- Drains the FIFO into the CRC engine's DATA/REFL write port, one write per CRC computation, pacing on the engine's ready (terminal-count) status.
- Lets software queue several words back-to-back instead of polling STAT between writes.
- CRC and POLY initialisation are still done by software directly on the CRC engine.

---
 rtl/crc_feeder.sv | 109 ++++++++++
 tb/tb_crc_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_feeder.sv
// Queues data words and feeds them one at a time into the CRC engine's DATA/REFL port.
// The next write waits until the engine reports idle, so software can push words back-to-back.
module crc_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16,
  localparam int unsigned LW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic [1:0]      in_size,
  input  logic            in_refl,
  input  logic            flush,
  input  logic            crc_ready,
  output logic            crc_cs,
  output logic [1:0]      crc_rs,
  output logic [3:0]      crc_wrl,
  output logic [31:0]     crc_d,
  output logic [LW-1:0]   level,
  output logic [CNTW-1:0] words_done,
  output logic            idle
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q;
  logic [31:0]   mem_data [DEPTH];
  logic [1:0]    mem_size [DEPTH];
  logic          mem_refl [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push, pop;

  function automatic logic [3:0] size_to_lanes(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign in_ready = (level_q != LW'(DEPTH));
  // A push coinciding with flush is dropped along with the queue.
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state_q == StIdle) && (level_q != '0) && crc_ready && !flush;
  assign level    = level_q;
  assign idle     = (level_q == '0) && (state_q == StIdle) && crc_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_size[wr_ptr_q] <= in_size;
      mem_refl[wr_ptr_q] <= in_refl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      words_done <= '0;
      crc_cs     <= 1'b0;
      crc_rs     <= 2'b00;
      crc_wrl    <= 4'b0000;
      crc_d      <= 32'h0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        level_q <= level_q + LW'(push) - LW'(pop);
      end

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            crc_cs  <= 1'b1;
            crc_rs  <= {1'b1, mem_refl[rd_ptr_q]};
            crc_wrl <= size_to_lanes(mem_size[rd_ptr_q]);
            crc_d   <= mem_data[rd_ptr_q];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          crc_cs     <= 1'b0;
          words_done <= words_done + CNTW'(1);
          state_q    <= StWait;
        end
        // Engine status only drops after the write edge, so skip one look at crc_ready.
        StWait: begin
          state_q <= StIdle;
        end
        default: begin
          crc_cs  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_feeder.sv
// Directed bench for crc_feeder: hand-computed expectations, with a busy-counter
// stand-in for the CRC engine that drops ready for a fixed time after each write.
module tb_crc_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        in_refl;
  logic        flush;
  logic        crc_ready;
  logic        crc_cs;
  logic [1:0]  crc_rs;
  logic [3:0]  crc_wrl;
  logic [31:0] crc_d;
  logic [2:0]  level;
  logic [3:0]  words_done;
  logic        idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc_feeder #(.DEPTH(4), .CNTW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_size    (in_size),
    .in_refl    (in_refl),
    .flush      (flush),
    .crc_ready  (crc_ready),
    .crc_cs     (crc_cs),
    .crc_rs     (crc_rs),
    .crc_wrl    (crc_wrl),
    .crc_d      (crc_d),
    .level      (level),
    .words_done (words_done),
    .idle       (idle)
  );

  // Engine stand-in: after a write edge, ready is low for busy_len cycles.
  logic model_en = 1'b0;
  logic ready_force = 1'b1;
  int   busy = 0;
  int   busy_len = 8;
  always @(posedge clk) begin
    if (crc_cs) busy <= busy_len;
    else if (busy > 0) busy <= busy - 1;
  end
  assign crc_ready = model_en ? (busy == 0) : ready_force;

  // Write log, sampled on the falling edge.
  int          cyc = 0;
  int          p_cyc[$];
  logic [31:0] p_d[$];
  logic [1:0]  p_rs[$];
  logic [3:0]  p_wrl[$];
  logic        full_win = 1'b0;
  logic        saw_full = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (crc_cs) begin
      p_cyc.push_back(cyc);
      p_d.push_back(crc_d);
      p_rs.push_back(crc_rs);
      p_wrl.push_back(crc_wrl);
    end
    if (full_win && !in_ready) saw_full <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    p_cyc.delete();
    p_d.delete();
    p_rs.delete();
    p_wrl.delete();
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] s, input logic r);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_size  = s;
    in_refl  = r;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n, input int budget);
    int k = 0;
    while (p_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, p_cyc.size(), n);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_size  = 2'b00;
    in_refl  = 1'b0;
    flush    = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    // Reset state
    chk("rst_level", level, 0);
    chk("rst_words", words_done, 0);
    chk("rst_cs", crc_cs, 0);
    chk("rst_rs", crc_rs, 0);
    chk("rst_wrl", crc_wrl, 0);
    chk("rst_d", crc_d, 0);
    chk("rst_idle", idle, 1);
    chk("rst_in_ready", in_ready, 1);

    // 1: single 32-bit word, write strobe on the cycle after the pop
    clear_log();
    push(32'h44332211, 2'b10, 1'b0);
    chk("t1_level_after_push", level, 1);
    step(1);
    chk("t1_cs", crc_cs, 1);
    chk("t1_rs", crc_rs, 2'b10);
    chk("t1_wrl", crc_wrl, 4'b1111);
    chk("t1_d", crc_d, 32'h44332211);
    chk("t1_level_popped", level, 0);
    step(1);
    chk("t1_cs_drop", crc_cs, 0);
    chk("t1_words", words_done, 1);
    step(2);
    chk("t1_pulses", p_cyc.size(), 1);
    chk("t1_idle", idle, 1);

    // 2: four bytes back-to-back, engine busy 8 cycles per write
    clear_log();
    model_en = 1'b1;
    busy_len = 8;
    full_win = 1'b1;
    push(32'h11, 2'b00, 1'b0);
    push(32'h22, 2'b00, 1'b0);
    push(32'h33, 2'b00, 1'b0);
    push(32'h44, 2'b00, 1'b0);
    full_win = 1'b0;
    wait_pulses("t2_pulses", 4, 80);
    for (int i = 1; i < p_cyc.size(); i++) chk("t2_spacing", p_cyc[i] - p_cyc[i-1], 10);
    for (int i = 0; i < p_d.size(); i++) begin
      chk("t2_d", p_d[i], 32'h11 * (i + 1));
      chk("t2_wrl", p_wrl[i], 4'b0001);
      chk("t2_rs", p_rs[i], 2'b10);
    end
    chk("t2_never_full", saw_full, 0);
    step(12);
    chk("t2_words", words_done, 5);

    // 3: engine held busy, fifth push back-pressured
    clear_log();
    model_en    = 1'b0;
    ready_force = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hA0 + i, 2'b00, 1'b0);
    chk("t3_level_full", level, 4);
    chk("t3_in_ready_low", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'hA4;
    in_size  = 2'b00;
    step(3);
    chk("t3_still_full", level, 4);
    chk("t3_no_issue", p_cyc.size(), 0);
    ready_force = 1'b1;
    push(32'hA4, 2'b00, 1'b0);
    wait_pulses("t3_pulses", 5, 60);
    for (int i = 0; i < p_d.size(); i++) chk("t3_order", p_d[i], 32'hA0 + i);
    step(4);
    chk("t3_words", words_done, 10);
    chk("t3_level_empty", level, 0);

    // 4: 16-bit REFL entry, and size 11 treated as 32-bit
    clear_log();
    push(32'h1234BEEF, 2'b01, 1'b1);
    push(32'hCAFEF00D, 2'b11, 1'b0);
    wait_pulses("t4_pulses", 2, 30);
    if (p_cyc.size() == 2) begin
      chk("t4_rs_refl", p_rs[0], 2'b11);
      chk("t4_wrl_16", p_wrl[0], 4'b0011);
      chk("t4_d_16", p_d[0], 32'h1234BEEF);
      chk("t4_rs_data", p_rs[1], 2'b10);
      chk("t4_wrl_11", p_wrl[1], 4'b1111);
      chk("t4_d_11", p_d[1], 32'hCAFEF00D);
    end
    step(4);
    chk("t4_words", words_done, 12);

    // 5: flush three queued entries; the simultaneous push is dropped
    clear_log();
    ready_force = 1'b0;
    for (int i = 0; i < 3; i++) push(32'hF0 + i, 2'b10, 1'b0);
    chk("t5_level_queued", level, 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    step(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_level_flushed", level, 0);
    step(2);
    ready_force = 1'b1;
    step(6);
    chk("t5_no_issue", p_cyc.size(), 0);
    chk("t5_words_kept", words_done, 12);
    chk("t5_idle", idle, 1);

    // 6: counter wraps at all-ones, then reset during an issue
    for (int i = 0; i < 3; i++) push(32'h100 + i, 2'b00, 1'b0);
    step(12);
    chk("t6_words_max", words_done, 15);
    push(32'h200, 2'b00, 1'b0);
    step(6);
    chk("t6_words_wrap", words_done, 0);
    ready_force = 1'b0;
    push(32'h300, 2'b10, 1'b0);
    push(32'h301, 2'b10, 1'b0);
    ready_force = 1'b1;
    step(1);
    chk("t6_cs_in_issue", crc_cs, 1);
    chk("t6_level_before", level, 1);
    reset = 1'b1;
    step(1);
    chk("t6_rst_cs", crc_cs, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_words", words_done, 0);
    chk("t6_rst_d", crc_d, 0);
    reset = 1'b0;
    step(4);
    chk("t6_after_rst_idle", idle, 1);
    chk("t6_after_rst_cs", crc_cs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
